// File: rtl/l16_ling_sub_pipe.sv
// l16_ling_sub_pipe: two-stage pipelined 16-bit ones'-complement add/subtract
// built on a sparse-2, radix-4 Ling prefix network with end-around carry.
// The carry chain is made cyclic, so the end-around carry falls out of the
// prefix tree directly and a + bb == 0xFFFF stays as -0 (0xFFFF).
module l16_ling_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int NP = WIDTH / 2;  // number of bit pairs / odd Ling nodes

  // Operand transform and per-bit generate/propagate/half-sum.
  logic [WIDTH-1:0] bb, g, p, x;
  assign bb = op ? ~b : b;
  assign g  = a & bb;
  assign p  = a | bb;
  assign x  = a ^ bb;

  // Stage-1 combinational: 4-bit Ling pseudo-carry at odd bits, 4-bit
  // propagate at even bits, both with cyclic wrap-around.
  logic [NP-1:0] h1, pr1, g_ev;
  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_stage1
      localparam int I  = 2 * gi + 1;
      localparam int I1 = (I + WIDTH - 1) % WIDTH;
      localparam int I2 = (I + WIDTH - 2) % WIDTH;
      localparam int I3 = (I + WIDTH - 3) % WIDTH;
      localparam int J  = 2 * gi;
      localparam int J1 = (J + WIDTH - 1) % WIDTH;
      localparam int J2 = (J + WIDTH - 2) % WIDTH;
      localparam int J3 = (J + WIDTH - 3) % WIDTH;
      assign h1[gi]   = g[I] | g[I1] | (p[I1] & g[I2]) | (p[I1] & p[I2] & g[I3]);
      assign pr1[gi]  = p[J] & p[J1] & p[J2] & p[J3];
      assign g_ev[gi] = g[J];
    end
  endgenerate

  // Stage-1 pipeline registers.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] x_q, x_d, p_q, p_d;
  logic [NP-1:0]    h1_q, h1_d, pr1_q, pr1_d, g_ev_q, g_ev_d;
  logic             a_msb_q, a_msb_d, bb_msb_q, bb_msb_d;

  // Stage-2 combinational: full-span cyclic Ling carries at odd bits, then
  // the sparse-2 sum, where each pair recovers its inner carry locally.
  logic [NP-1:0]    h2, cin;
  logic [WIDTH-1:0] sum;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_stage2
      localparam int K2  = (gi + NP - 2) % NP;
      localparam int K4  = (gi + NP - 4) % NP;
      localparam int K6  = (gi + NP - 6) % NP;
      localparam int KM1 = (gi + NP - 1) % NP;
      localparam int PB  = (2 * gi + WIDTH - 1) % WIDTH;
      localparam int E   = 2 * gi;
      localparam int O   = 2 * gi + 1;
      assign h2[gi]  = h1_q[gi]
                     | (pr1_q[gi] & h1_q[K2])
                     | (pr1_q[gi] & pr1_q[K2] & h1_q[K4])
                     | (pr1_q[gi] & pr1_q[K2] & pr1_q[K4] & h1_q[K6]);
      // Real carry into the even bit of this pair: c = p & H at bit below.
      assign cin[gi] = p_q[PB] & h2[KM1];
      assign sum[E]  = x_q[E] ^ cin[gi];
      assign sum[O]  = x_q[O] ^ (g_ev_q[gi] | (p_q[E] & cin[gi]));
    end
  endgenerate

  // Stage-2 pipeline registers (these are the outputs).
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;

  // Elastic handshake: a stage advances when downstream takes or it is empty.
  logic s1_adv, s2_adv;
  assign s2_adv   = out_ready | ~s2_valid_q;
  assign s1_adv   = s2_adv | ~s1_valid_q;
  assign in_ready = s1_adv;

  // Next-state: load on transfer, otherwise hold payload stable.
  always_comb begin
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    p_d        = p_q;
    h1_d       = h1_q;
    pr1_d      = pr1_q;
    g_ev_d     = g_ev_q;
    a_msb_d    = a_msb_q;
    bb_msb_d   = bb_msb_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        x_d      = x;
        p_d      = p;
        h1_d     = h1;
        pr1_d    = pr1;
        g_ev_d   = g_ev;
        a_msb_d  = a[WIDTH-1];
        bb_msb_d = bb[WIDTH-1];
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d  = sum;
        zero_d = (sum == '0) | (sum == '1);
        ovf_d  = (a_msb_q == bb_msb_q) & (sum[WIDTH-1] != a_msb_q);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      p_q        <= '0;
      h1_q       <= '0;
      pr1_q      <= '0;
      g_ev_q     <= '0;
      a_msb_q    <= 1'b0;
      bb_msb_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      x_q        <= x_d;
      p_q        <= p_d;
      h1_q       <= h1_d;
      pr1_q      <= pr1_d;
      g_ev_q     <= g_ev_d;
      a_msb_q    <= a_msb_d;
      bb_msb_q   <= bb_msb_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_l16_ling_sub_pipe.sv
// Scoreboard bench for l16_ling_sub_pipe: directed corner cases, backpressure,
// mid-stream reset and a long randomized run against a plain-arithmetic model.
module tb_l16_ling_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        zero;
  logic        ovf;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        v;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  l16_ling_sub_pipe #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: ones'-complement add = binary add plus end-around carry.
  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi, input logic opi);
    logic [15:0] bbm;
    logic [16:0] s;
    exp_t        e;
    bbm   = opi ? ~bi : bi;
    s     = {1'b0, ai} + {1'b0, bbm};
    e.res = s[15:0] + {15'd0, s[16]};
    e.z   = (e.res == 16'h0000) || (e.res == 16'hFFFF);
    e.v   = (ai[15] == bbm[15]) && (e.res[15] != ai[15]);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic z, input logic v, input bit lat);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.v   = v;
    e.acc = 0;
    e.lat = lat;
    return e;
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] t;
    case ($urandom_range(0, 9))
      0:       t = 16'hFFFF;
      1:       t = 16'h0000;
      2:       t = 16'h7FFF;
      3:       t = 16'h8000;
      default: t = 16'($urandom);
    endcase
    return t;
  endfunction

  // Present one operand and hold it until accepted (bounded).
  task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic opi, input exp_t e);
    int w;
    bit done;
    w    = 0;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a  = ai;
    b  = bi;
    op = opi;
    while (!done) begin
      #4;
      if (in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end else if (++w > 50) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && sb.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares on every output transfer; checks hold on stall.
  initial begin
    bit          stall_q;
    logic [17:0] held;
    exp_t        e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_payload", 32'({result, zero, ovf}), 32'(held));
        end
        stall_q = out_valid && !out_ready;
        held    = {result, zero, ovf};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
          end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("zero", 32'(zero), 32'(e.z));
            chk("ovf", 32'(ovf), 32'(e.v));
            if (e.lat) chk("latency", cyc - e.acc, 32'd2);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rop;
    bit          pend;
    int          sent, k;
    logic [15:0] bpa[4];
    logic [15:0] bpb[4];
    logic        bpo[4];
    exp_t        e;

    // Reset state while rst_n is held low, then release between edges.
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #11 rst_n = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed corner cases with the consumer always ready.
    out_ready = 1'b1;
    send(16'h0005, 16'h0003, 1'b0, mk(16'h0008, 1'b0, 1'b0, 1'b1));
    send(16'hFFFE, 16'hFFFE, 1'b0, mk(16'hFFFD, 1'b0, 1'b0, 1'b1));
    send(16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1'b0, 1'b0, 1'b1));
    send(16'hFFFE, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b1));
    send(16'h1234, 16'h1234, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b1));
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b1));
    send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b1));
    send(16'h0000, 16'h0000, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    wait_empty(20);

    // Backpressure: 4 ops, consumer stalled for 5 cycles then released.
    for (int i = 0; i < 4; i++) begin
      bpa[i] = 16'($urandom);
      bpb[i] = 16'($urandom);
      bpo[i] = 1'($urandom);
    end
    k = 0;
    for (int c = 0; c < 25 && k < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = 1'b1;
      a  = bpa[k];
      b  = bpb[k];
      op = bpo[k];
      #4;
      if (c >= 2 && c < 5) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (c == 5) chk("bp_in_ready_release", 32'(in_ready), 32'd1);
      if (in_ready) begin
        e = model(bpa[k], bpb[k], bpo[k]);
        e.acc = cyc;
        sb.push_back(e);
        k++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_accepted", 32'(k), 32'd4);
    wait_empty(20);

    // Reset mid-stream: two ops in flight, async pulse between edges.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    send(16'h3333, 16'h0444, 1'b1, model(16'h3333, 16'h0444, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    #5 rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h0100, 16'h0023, 1'b0, mk(16'h0123, 1'b0, 1'b0, 1'b1));
    wait_empty(20);

    // Randomized stream with random valid/ready.
    sent = 0;
    pend = 1'b0;
    ra   = 16'h0;
    rb   = 16'h0;
    rop  = 1'b0;
    while (sent < 10000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < 70);
      if (!pend && $urandom_range(0, 99) < 75) begin
        ra   = pick();
        rb   = pick();
        rop  = 1'($urandom);
        pend = 1'b1;
      end
      in_valid = pend;
      a  = ra;
      b  = rb;
      op = rop;
      #4;
      if (pend && in_ready) begin
        e = model(ra, rb, rop);
        e.acc = cyc;
        sb.push_back(e);
        pend = 1'b0;
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
